i2c_slave_regfile: RTL and testbench

Parametrised multi-address I2C slave register file, the successor to the current slave memory block. It sits behind the I2C bit-level front end and exchanges whole bytes with it. It matches the received address byte against a list of ADDRESSNUM 7-bit addresses and serves NBYTES registers per address, with a register pointer, auto-increment, repeated-START support and a host-side access port. Single clock, fully synchronous.

---
 rtl/i2c_slave_regfile_if.sv | 38 +++
 rtl/i2c_slave_regfile.sv | 188 ++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_regfile_if.sv
// Byte-level link between the I2C bit front end and the slave register file.
//   slave  modport: used by the register file (takes events/bytes, returns ACK and read data)
//   master modport: used by the front end (or a bench standing in for it)
// Signals:
//   start_det/stop_det  one-cycle START (incl. repeated START) / STOP pulses
//   rx_valid/rx_byte    completed received byte
//   tx_req              front end asks for the next read byte
//   ack_valid/ack       ACK(1)/NACK(0) decision, one cycle after rx_valid
//   tx_valid/tx_byte    read byte, one cycle after tx_req
//   addr_found/addr_index/rw  status of the currently addressed slot
interface i2c_slave_regfile_if #(
    parameter int ADDRESSNUM = 2
);
    localparam int IW = (ADDRESSNUM > 1) ? $clog2(ADDRESSNUM) : 1;

    logic          start_det;
    logic          stop_det;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          tx_req;
    logic          ack_valid;
    logic          ack;
    logic          tx_valid;
    logic [7:0]    tx_byte;
    logic          addr_found;
    logic [IW-1:0] addr_index;
    logic          rw;

    modport slave (
        input  start_det, stop_det, rx_valid, rx_byte, tx_req,
        output ack_valid, ack, tx_valid, tx_byte, addr_found, addr_index, rw
    );

    modport master (
        output start_det, stop_det, rx_valid, rx_byte, tx_req,
        input  ack_valid, ack, tx_valid, tx_byte, addr_found, addr_index, rw
    );
endinterface

// File: rtl/i2c_slave_regfile.sv
// Multi-address I2C slave register file. Matches the address byte against
// ADDRESSNUM 7-bit addresses, serves NBYTES registers per address with a
// register pointer, auto-increment (wrap or saturate) and repeated START.
// Ports:
//   sys_clk, rst      clock, synchronous active-high reset
//   enable            0: NACK every address byte (host port still active)
//   address_list      slot i at bits [7i+6:7i]
//   bus               byte-level front-end link (slave modport)
//   host_we/addr/wdata host write port, flat index slot*NBYTES+reg
//   host_rdata        registered read of host_addr (1-cycle latency)
//   mem_flat          all register bytes, byte k at bits [8k+7:8k]
module i2c_slave_regfile #(
    parameter int ADDRESSNUM = 2,
    parameter int NBYTES     = 2,
    parameter int WRAP       = 1,
    localparam int TOTAL     = ADDRESSNUM * NBYTES,
    localparam int HW        = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
    input  logic                      sys_clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [7*ADDRESSNUM-1:0]   address_list,
    i2c_slave_regfile_if.slave        bus,
    input  logic                      host_we,
    input  logic [HW-1:0]             host_addr,
    input  logic [7:0]                host_wdata,
    output logic [7:0]                host_rdata,
    output logic [8*TOTAL-1:0]        mem_flat
);
    localparam int IW = (ADDRESSNUM > 1) ? $clog2(ADDRESSNUM) : 1;
    localparam int PW = $clog2(NBYTES);
    localparam logic [PW-1:0] LAST = PW'(NBYTES - 1);

    typedef enum logic [2:0] {IDLE, ADDR, PTR, WDATA, RDATA, IGNORE} state_t;

    state_t               state_q, state_d;
    logic [TOTAL-1:0][7:0] mem;
    logic [PW-1:0]        ptr_q, ptr_d;
    // Set once the last register was written with WRAP=0; later bytes are NACKed.
    logic                 full_q, full_d;
    logic                 found_q, found_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 rw_q, rw_d;
    logic                 ack_valid_q, ack_valid_d;
    logic                 ack_q, ack_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [7:0]           tx_byte_q, tx_byte_d;
    logic                 bus_we;
    logic [HW-1:0]        bus_addr;
    logic                 match;
    logic [IW-1:0]        match_idx;
    logic                 host_ok;

    assign bus_addr = HW'(idx_q) * HW'(NBYTES) + HW'(ptr_q);
    assign host_ok  = (32'(host_addr) < 32'(TOTAL));
    assign mem_flat = mem;

    // Descending scan so the lowest matching slot overwrites any higher one.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = ADDRESSNUM - 1; i >= 0; i--) begin
            if (bus.rx_byte[7:1] == address_list[7*i +: 7]) begin
                match     = 1'b1;
                match_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        full_d      = full_q;
        found_d     = found_q;
        idx_d       = idx_q;
        rw_d        = rw_q;
        ack_valid_d = 1'b0;
        ack_d       = 1'b0;
        tx_valid_d  = 1'b0;
        tx_byte_d   = tx_byte_q;
        bus_we      = 1'b0;

        if (bus.start_det) begin
            state_d = ADDR;
            found_d = 1'b0;
        end else if (bus.stop_det) begin
            state_d = IDLE;
            found_d = 1'b0;
        end else if (bus.rx_valid) begin
            // RDATA swallows stray bytes silently; every other state answers.
            ack_valid_d = (state_q != RDATA);
            case (state_q)
                ADDR: begin
                    if (match && enable) begin
                        ack_d   = 1'b1;
                        found_d = 1'b1;
                        idx_d   = match_idx;
                        rw_d    = bus.rx_byte[0];
                        state_d = bus.rx_byte[0] ? RDATA : PTR;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                PTR: begin
                    if ({1'b0, bus.rx_byte} < 9'(NBYTES)) begin
                        ack_d   = 1'b1;
                        ptr_d   = bus.rx_byte[PW-1:0];
                        full_d  = 1'b0;
                        state_d = WDATA;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                WDATA: begin
                    if (!full_q) begin
                        bus_we = 1'b1;
                        ack_d  = 1'b1;
                        if (ptr_q == LAST) begin
                            if (WRAP != 0) ptr_d  = '0;
                            else           full_d = 1'b1;
                        end else begin
                            ptr_d = ptr_q + PW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end else if (bus.tx_req) begin
            tx_valid_d = 1'b1;
            if (state_q == RDATA) begin
                tx_byte_d = mem[bus_addr];
                if (ptr_q == LAST) begin
                    if (WRAP != 0) ptr_d = '0;
                end else begin
                    ptr_d = ptr_q + PW'(1);
                end
            end else begin
                tx_byte_d = 8'hFF;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            full_q      <= 1'b0;
            found_q     <= 1'b0;
            idx_q       <= '0;
            rw_q        <= 1'b0;
            ack_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_byte_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            full_q      <= full_d;
            found_q     <= found_d;
            idx_q       <= idx_d;
            rw_q        <= rw_d;
            ack_valid_q <= ack_valid_d;
            ack_q       <= ack_d;
            tx_valid_q  <= tx_valid_d;
            tx_byte_q   <= tx_byte_d;
        end
    end

    // Bus write is issued after the host write so it wins on a same-byte collision.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            mem        <= '0;
            host_rdata <= 8'h00;
        end else begin
            if (host_we && host_ok) mem[host_addr] <= host_wdata;
            if (bus_we)             mem[bus_addr]  <= bus.rx_byte;
            host_rdata <= host_ok ? mem[host_addr] : 8'h00;
        end
    end

    assign bus.ack_valid  = ack_valid_q;
    assign bus.ack        = ack_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_byte    = tx_byte_q;
    assign bus.addr_found = found_q;
    assign bus.addr_index = idx_q;
    assign bus.rw         = rw_q;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: dut0 (WRAP=1) and dut1 (WRAP=0), both with
// ADDRESSNUM=2, NBYTES=2 and slot0=0x0F, slot1=0x0C. 'sel' routes the
// stimulus to one DUT. Expected ACKs/read bytes (with their due cycle) go
// into queues; a negedge monitor pops and compares.
module tb_i2c_slave_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        sel;
    logic [13:0] address_list;
    logic        start_det, stop_det, rx_valid, tx_req;
    logic [7:0]  rx_byte;
    logic        host_we;
    logic [1:0]  host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata0, host_rdata1;
    logic [31:0] mem0, mem1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] v;
        int         cyc;
    } exp_t;
    exp_t ack_q[$];
    exp_t tx_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_slave_regfile_if #(.ADDRESSNUM(2)) if0 ();
    i2c_slave_regfile_if #(.ADDRESSNUM(2)) if1 ();

    assign if0.start_det = start_det & ~sel;
    assign if0.stop_det  = stop_det  & ~sel;
    assign if0.rx_valid  = rx_valid  & ~sel;
    assign if0.tx_req    = tx_req    & ~sel;
    assign if0.rx_byte   = rx_byte;
    assign if1.start_det = start_det & sel;
    assign if1.stop_det  = stop_det  & sel;
    assign if1.rx_valid  = rx_valid  & sel;
    assign if1.tx_req    = tx_req    & sel;
    assign if1.rx_byte   = rx_byte;

    i2c_slave_regfile #(.ADDRESSNUM(2), .NBYTES(2), .WRAP(1)) dut0 (
        .sys_clk(clk), .rst(rst), .enable(enable), .address_list(address_list),
        .bus(if0), .host_we(host_we & ~sel), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata0), .mem_flat(mem0)
    );

    i2c_slave_regfile #(.ADDRESSNUM(2), .NBYTES(2), .WRAP(0)) dut1 (
        .sys_clk(clk), .rst(rst), .enable(enable), .address_list(address_list),
        .bus(if1), .host_we(host_we & sel), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata1), .mem_flat(mem1)
    );

    wire       m_ack_valid = sel ? if1.ack_valid  : if0.ack_valid;
    wire       m_ack       = sel ? if1.ack        : if0.ack;
    wire       m_tx_valid  = sel ? if1.tx_valid   : if0.tx_valid;
    wire [7:0] m_tx_byte   = sel ? if1.tx_byte    : if0.tx_byte;
    wire       m_found     = sel ? if1.addr_found : if0.addr_found;
    wire       m_idx       = sel ? if1.addr_index[0] : if0.addr_index[0];
    wire       m_rw        = sel ? if1.rw         : if0.rw;

    // Monitor: every ack_valid/tx_valid must match the oldest expectation and its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (m_ack_valid) begin
            checks++;
            if (ack_q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected: ack=%0d at cycle %0d, no ack expected", m_ack, cyc);
            end else begin
                e = ack_q.pop_front();
                if (m_ack !== e.v[0] || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL ack: got ack=%0d at cycle %0d, want ack=%0d at cycle %0d",
                             m_ack, cyc, e.v[0], e.cyc);
                end
            end
        end
        if (m_tx_valid) begin
            checks++;
            if (tx_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: tx_byte=%02h at cycle %0d", m_tx_byte, cyc);
            end else begin
                e = tx_q.pop_front();
                if (m_tx_byte !== e.v || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL tx_byte: got %02h at cycle %0d, want %02h at cycle %0d",
                             m_tx_byte, cyc, e.v, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    // All tasks start and end at posedge+1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start_det = 1'b1;
        tick();
        start_det = 1'b0;
    endtask

    task automatic do_stop();
        stop_det = 1'b1;
        tick();
        stop_det = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic exp_ack);
        rx_valid = 1'b1;
        rx_byte  = b;
        ack_q.push_back('{v: {7'd0, exp_ack}, cyc: cyc + 1});
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_silent(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic rd(input logic [7:0] exp_b);
        tx_req = 1'b1;
        tx_q.push_back('{v: exp_b, cyc: cyc + 1});
        tick();
        tx_req = 1'b0;
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] d);
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        tick();
        host_we    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enable = 1'b1; sel = 1'b0;
        address_list = {7'h0C, 7'h0F};
        start_det = 0; stop_det = 0; rx_valid = 0; tx_req = 0; rx_byte = 0;
        host_we = 0; host_addr = 0; host_wdata = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_ack_valid", {31'd0, if0.ack_valid}, 0);
        chk("rst_tx_valid",  {31'd0, if0.tx_valid}, 0);
        chk("rst_found",     {31'd0, if0.addr_found}, 0);
        chk("rst_idx_rw",    {30'd0, if0.addr_index[0], if0.rw}, 0);
        chk("rst_tx_byte",   {24'd0, if0.tx_byte}, 0);
        chk("rst_host_rdata", {24'd0, host_rdata0}, 0);
        chk("rst_mem0", mem0, 0);
        chk("rst_mem1", mem1, 0);

        // Write transaction with wrap: reg1=AA then reg0=55
        do_start();
        send(8'h1E, 1);
        chk("wr_found", {31'd0, m_found}, 1);
        chk("wr_idx_rw", {30'd0, m_idx, m_rw}, 0);
        send(8'h01, 1);
        send(8'hAA, 1);
        send(8'h55, 1);
        chk("wr_mem", mem0, 32'h0000AA55);
        do_stop();
        chk("wr_found_after_stop", {31'd0, m_found}, 0);

        // Repeated-START read of empty slot1, with a stray byte ignored in RDATA
        do_start();
        send(8'h18, 1);
        send(8'h00, 1);
        do_start();
        send(8'h19, 1);
        chk("rd_idx_rw", {30'd0, m_idx, m_rw}, 32'd3);
        rd(8'h00);
        send_silent(8'h42);
        rd(8'h00);
        rd(8'h00);
        do_stop();

        // Host preload of slot1, then the same read returns 11,22,11
        host_write(2'd2, 8'h11);
        host_write(2'd3, 8'h22);
        chk("host_mem", mem0, 32'h2211AA55);
        host_addr = 2'd3;
        tick();
        chk("host_rdata", {24'd0, host_rdata0}, 32'h22);
        do_start();
        send(8'h18, 1);
        send(8'h00, 1);
        do_start();
        send(8'h19, 1);
        rd(8'h11);
        rd(8'h22);
        rd(8'h11);
        do_stop();

        // No address match
        do_start();
        send(8'h40, 0);
        chk("nomatch_found", {31'd0, m_found}, 0);
        send(8'h12, 0);
        rd(8'hFF);
        chk("nomatch_mem", mem0, 32'h2211AA55);
        do_stop();

        // Bad pointer
        do_start();
        send(8'h1E, 1);
        send(8'h05, 0);
        send(8'h77, 0);
        chk("badptr_mem", mem0, 32'h2211AA55);
        do_stop();

        // Saturation on the WRAP=0 instance
        sel = 1'b1;
        tick();
        do_start();
        send(8'h1E, 1);
        send(8'h00, 1);
        send(8'hA1, 1);
        send(8'hB2, 1);
        send(8'hC3, 0);
        chk("sat_mem", mem1, 32'h0000B2A1);
        do_stop();
        do_start();
        send(8'h1E, 1);
        send(8'h01, 1);
        do_start();
        send(8'h1F, 1);
        rd(8'hB2);
        rd(8'hB2);
        do_stop();
        sel = 1'b0;
        tick();

        // Collision: bus write beats host write to the same byte
        do_start();
        send(8'h1E, 1);
        send(8'h00, 1);
        host_we = 1'b1; host_addr = 2'd0; host_wdata = 8'h99;
        send(8'h5A, 1);
        host_we = 1'b0;
        chk("collision_mem", mem0, 32'h2211AA5A);
        do_stop();

        // enable=0: address NACKed, host write still lands
        enable = 1'b0;
        do_start();
        send(8'h1E, 0);
        chk("disabled_found", {31'd0, m_found}, 0);
        host_write(2'd1, 8'h3C);
        chk("disabled_host_mem", mem0, 32'h22113C5A);
        host_addr = 2'd1;
        tick();
        chk("disabled_host_rdata", {24'd0, host_rdata0}, 32'h3C);
        do_stop();
        enable = 1'b1;

        // Reset in the middle of a write
        do_start();
        send(8'h1E, 1);
        send(8'h00, 1);
        send(8'h12, 1);
        chk("pre_rst_mem", mem0, 32'h22113C12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_mem", mem0, 0);
        chk("midrst_found", {31'd0, m_found}, 0);
        send(8'h34, 0);
        chk("midrst_mem_after", mem0, 0);

        repeat (3) tick();
        chk("ack_queue_drained", ack_q.size(), 0);
        chk("tx_queue_drained", tx_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
